ctrl_pipe_regs: RTL and testbench

Parametrised control-signal pipeline for the ARM pipeline core. It carries the decoded control bundle from decode (ID) through the EX, MEM and WB stages and adds behaviour the earlier fixed-width register chain lacked:
- per-stage valid bits
- stall bubble insertion
- branch flush
- ARM condition-code squash in EX
- a global freeze for memory wait

It sits between Control_Unit and the datapath stage logic.

---
 rtl/ctrl_pipe_pkg.sv | 38 +++
 rtl/ctrl_pipe_stage.sv | 55 +++++
 rtl/ctrl_pipe_regs.sv | 135 +++++++++++++
 tb/tb_ctrl_pipe_regs.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared widths, control-field bit positions and the default
// ID->EX control bundle layout for the ARM pipeline control registers.
//   EX bundle  (MSB->LSB): {opcode[3:0], am[1:0], s, load, size, rw, e, rf_e}
//   MEM bundle: low bits of EX bundle {load, size, rw, e, rf_e}
//   WB bundle : low bits of MEM bundle {rf_e}
package ctrl_pipe_pkg;

    // Field positions, built LSB upward so the default widths follow from them.
    localparam int unsigned RF_E_B  = 0;
    localparam int unsigned E_B     = RF_E_B + 1;
    localparam int unsigned RW_B    = E_B + 1;
    localparam int unsigned SIZE_B  = RW_B + 1;
    localparam int unsigned LOAD_B  = SIZE_B + 1;
    localparam int unsigned S_B     = LOAD_B + 1;
    localparam int unsigned AM_LSB  = S_B + 1;
    localparam int unsigned AM_MSB  = AM_LSB + 1;
    localparam int unsigned OPC_LSB = AM_MSB + 1;
    localparam int unsigned OPC_MSB = OPC_LSB + 3;

    // Default bundle widths.
    localparam int unsigned EX_W_DEF  = OPC_MSB + 1;
    localparam int unsigned MEM_W_DEF = LOAD_B + 1;
    localparam int unsigned WB_W_DEF  = RF_E_B + 1;
    localparam int unsigned CNT_W_DEF = 16;

    // Default EX control bundle.
    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] am;
        logic       s;
        logic       load;
        logic       size;
        logic       rw;
        logic       e;
        logic       rf_e;
    } ex_ctrl_t;

endpackage : ctrl_pipe_pkg

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one pipeline stage register holding a valid bit and a
// control bundle. A stage that is not valid always holds ctrl = 0.
//   clk, reset : clock, synchronous active-high reset
//   hold_i     : keep current contents (freeze)
//   bubble_i   : load an empty slot instead of the incoming bundle
//   valid_i    : incoming bundle is a real instruction
//   ctrl_i     : incoming control bundle
//   valid_o    : registered valid
//   ctrl_o     : registered control bundle
module ctrl_pipe_stage #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold_i,
    input  logic         bubble_i,
    input  logic         valid_i,
    input  logic [W-1:0] ctrl_i,
    output logic         valid_o,
    output logic [W-1:0] ctrl_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] ctrl_q,  ctrl_d;

    // Next state: hold, bubble (also for an invalid input), or load.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        if (!hold_i) begin
            if (bubble_i || !valid_i) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end else begin
                valid_d = 1'b1;
                ctrl_d  = ctrl_i;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;

endmodule : ctrl_pipe_stage

// File: rtl/ctrl_pipe_regs.sv
// ctrl_pipe_regs: control-signal pipeline ID->EX->MEM->WB with per-stage
// valid bits, stall bubbles, branch flush, condition-code squash in EX and a
// global freeze. Optional saturating performance counters are enabled by the
// macro CTRL_PIPE_PERF_EN.
//   clk, reset            : clock, synchronous active-high reset
//   id_valid, id_ctrl     : instruction and control bundle from decode
//   stall                 : load-use hazard, ID held upstream (EX bubble)
//   flush                 : branch taken in EX, kill the ID instruction
//   freeze                : hold every stage and counter
//   ex_cond_pass          : condition codes satisfied for the EX instruction
//   ex/mem/wb_valid, _ctrl: registered stage contents
//   bubble/squash/retire_cnt : performance counters (CTRL_PIPE_PERF_EN only)
module ctrl_pipe_regs
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned EX_W  = EX_W_DEF,
    parameter int unsigned MEM_W = MEM_W_DEF,
    parameter int unsigned WB_W  = WB_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [EX_W-1:0]  id_ctrl,
    input  logic             stall,
    input  logic             flush,
    input  logic             freeze,
    input  logic             ex_cond_pass,
    output logic             ex_valid,
    output logic [EX_W-1:0]  ex_ctrl,
    output logic             mem_valid,
    output logic [MEM_W-1:0] mem_ctrl,
    output logic             wb_valid,
    output logic [WB_W-1:0]  wb_ctrl
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] squash_cnt,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    // Width sanity checks at elaboration.
    if (MEM_W > EX_W) begin : g_err_mem_w
        $error("ctrl_pipe_regs: MEM_W must not exceed EX_W");
    end
    if (WB_W > MEM_W) begin : g_err_wb_w
        $error("ctrl_pipe_regs: WB_W must not exceed MEM_W");
    end
    if (CNT_W == 0) begin : g_err_cnt_w
        $error("ctrl_pipe_regs: CNT_W must be at least 1");
    end

    // EX: a stall or flush replaces the ID instruction with a bubble.
    ctrl_pipe_stage #(.W(EX_W)) u_ex (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (freeze),
        .bubble_i (stall | flush),
        .valid_i  (id_valid),
        .ctrl_i   (id_ctrl),
        .valid_o  (ex_valid),
        .ctrl_o   (ex_ctrl)
    );

    // MEM: a failed condition squashes the EX instruction.
    ctrl_pipe_stage #(.W(MEM_W)) u_mem (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (freeze),
        .bubble_i (1'b0),
        .valid_i  (ex_valid & ex_cond_pass),
        .ctrl_i   (ex_ctrl[MEM_W-1:0]),
        .valid_o  (mem_valid),
        .ctrl_o   (mem_ctrl)
    );

    // WB: plain advance.
    ctrl_pipe_stage #(.W(WB_W)) u_wb (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (freeze),
        .bubble_i (1'b0),
        .valid_i  (mem_valid),
        .ctrl_i   (mem_ctrl[WB_W-1:0]),
        .valid_o  (wb_valid),
        .ctrl_o   (wb_ctrl)
    );

`ifdef CTRL_PIPE_PERF_EN
    localparam int unsigned SUM_W = CNT_W + 2;

    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [1:0]       squash_inc;
    logic [SUM_W-1:0] bubble_sum, squash_sum, retire_sum;

    // Flush of a live ID instruction and a condition squash can coincide.
    assign squash_inc = 2'(flush & id_valid) + 2'(ex_valid & ~ex_cond_pass);

    // Saturating increments; counters hold under freeze.
    always_comb begin
        bubble_sum   = SUM_W'(bubble_cnt_q) + SUM_W'(stall & id_valid & ~flush);
        squash_sum   = SUM_W'(squash_cnt_q) + SUM_W'(squash_inc);
        retire_sum   = SUM_W'(retire_cnt_q) + SUM_W'(wb_valid);
        bubble_cnt_d = bubble_cnt_q;
        squash_cnt_d = squash_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (!freeze) begin
            bubble_cnt_d = (bubble_sum[SUM_W-1:CNT_W] != '0) ? '1 : bubble_sum[CNT_W-1:0];
            squash_cnt_d = (squash_sum[SUM_W-1:CNT_W] != '0) ? '1 : squash_sum[CNT_W-1:0];
            retire_cnt_d = (retire_sum[SUM_W-1:CNT_W] != '0) ? '1 : retire_sum[CNT_W-1:0];
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            squash_cnt_q <= '0;
            retire_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            squash_cnt_q <= squash_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign squash_cnt = squash_cnt_q;
    assign retire_cnt = retire_cnt_q;
`endif

endmodule : ctrl_pipe_regs

// File: tb/tb_ctrl_pipe_regs.sv
// tb_ctrl_pipe_regs: directed bench for ctrl_pipe_regs. Counter checks are
// compiled in only when CTRL_PIPE_PERF_EN is defined.
module tb_ctrl_pipe_regs;

    localparam int unsigned EX_W  = 12;
    localparam int unsigned MEM_W = 5;
    localparam int unsigned WB_W  = 1;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [EX_W-1:0]  id_ctrl;
    logic             stall;
    logic             flush;
    logic             freeze;
    logic             ex_cond_pass;
    logic             ex_valid;
    logic [EX_W-1:0]  ex_ctrl;
    logic             mem_valid;
    logic [MEM_W-1:0] mem_ctrl;
    logic             wb_valid;
    logic [WB_W-1:0]  wb_ctrl;
`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] squash_cnt;
    logic [CNT_W-1:0] retire_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_pipe_regs #(
        .EX_W  (EX_W),
        .MEM_W (MEM_W),
        .WB_W  (WB_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .stall        (stall),
        .flush        (flush),
        .freeze       (freeze),
        .ex_cond_pass (ex_cond_pass),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .mem_valid    (mem_valid),
        .mem_ctrl     (mem_ctrl),
        .wb_valid     (wb_valid),
        .wb_ctrl      (wb_ctrl)
`ifdef CTRL_PIPE_PERF_EN
        ,
        .bubble_cnt   (bubble_cnt),
        .squash_cnt   (squash_cnt),
        .retire_cnt   (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One clock edge, then settle before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pipe(input string tag,
                            input logic ev, input logic [EX_W-1:0] ec,
                            input logic mv, input logic [MEM_W-1:0] mc,
                            input logic wv, input logic [WB_W-1:0] wc);
        chk({tag, ".ex_valid"},  16'(ex_valid),  16'(ev));
        chk({tag, ".ex_ctrl"},   16'(ex_ctrl),   16'(ec));
        chk({tag, ".mem_valid"}, 16'(mem_valid), 16'(mv));
        chk({tag, ".mem_ctrl"},  16'(mem_ctrl),  16'(mc));
        chk({tag, ".wb_valid"},  16'(wb_valid),  16'(wv));
        chk({tag, ".wb_ctrl"},   16'(wb_ctrl),   16'(wc));
    endtask

    task automatic chk_cnt(input string tag, input int b, input int s, input int r);
`ifdef CTRL_PIPE_PERF_EN
        chk({tag, ".bubble_cnt"}, 16'(bubble_cnt), 16'(b));
        chk({tag, ".squash_cnt"}, 16'(squash_cnt), 16'(s));
        chk({tag, ".retire_cnt"}, 16'(retire_cnt), 16'(r));
`else
        if (tag.len() == 0 && b + s + r < 0) $display("unused");
`endif
    endtask

    initial begin
        reset        = 1'b1;
        id_valid     = 1'b1;
        id_ctrl      = 12'hA53;
        stall        = 1'b0;
        flush        = 1'b0;
        freeze       = 1'b0;
        ex_cond_pass = 1'b1;

        // Reset with a live instruction presented: nothing enters.
        cyc();
        cyc();
        chk_pipe("reset", 1'b0, 12'h000, 1'b0, 5'h00, 1'b0, 1'b0);
        chk_cnt("reset", 0, 0, 0);

        // Stream 12'hA53: EX at edge 1, MEM (5'h13) at edge 2, WB (1) at edge 3.
        reset = 1'b0;
        cyc();
        chk_pipe("e1", 1'b1, 12'hA53, 1'b0, 5'h00, 1'b0, 1'b0);
        cyc();
        chk_pipe("e2", 1'b1, 12'hA53, 1'b1, 5'h13, 1'b0, 1'b0);
        cyc();
        chk_pipe("e3", 1'b1, 12'hA53, 1'b1, 5'h13, 1'b1, 1'b1);
        chk_cnt("e3", 0, 0, 0);

        // Stall: EX bubble while MEM/WB keep advancing.
        stall = 1'b1;
        cyc();
        chk_pipe("stall", 1'b0, 12'h000, 1'b1, 5'h13, 1'b1, 1'b1);
        chk_cnt("stall", 1, 0, 1);

        // Stall and flush together: bubble classified as a squash.
        flush = 1'b1;
        cyc();
        chk_pipe("stall_flush", 1'b0, 12'h000, 1'b0, 5'h00, 1'b1, 1'b1);
        chk_cnt("stall_flush", 1, 1, 2);

        // Load 12'hFFF into EX.
        stall   = 1'b0;
        flush   = 1'b0;
        id_ctrl = 12'hFFF;
        cyc();
        chk_pipe("fff", 1'b1, 12'hFFF, 1'b0, 5'h00, 1'b0, 1'b0);
        chk_cnt("fff", 1, 1, 3);

        // Failed condition on 12'hFFF: MEM gets a bubble.
        id_ctrl      = 12'h0C1;
        ex_cond_pass = 1'b0;
        cyc();
        chk_pipe("cond_fail", 1'b1, 12'h0C1, 1'b0, 5'h00, 1'b0, 1'b0);
        chk_cnt("cond_fail", 1, 2, 3);

        // Invalid ID with nonzero ctrl: EX stays zero.
        ex_cond_pass = 1'b1;
        id_valid     = 1'b0;
        id_ctrl      = 12'h7FF;
        cyc();
        chk_pipe("id_invalid", 1'b0, 12'h000, 1'b1, 5'h01, 1'b0, 1'b0);

        // Freeze 4 edges; flush/stall/cond events must not act or count.
        freeze       = 1'b1;
        flush        = 1'b1;
        id_valid     = 1'b1;
        id_ctrl      = 12'hA53;
        ex_cond_pass = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_pipe("freeze", 1'b0, 12'h000, 1'b1, 5'h01, 1'b0, 1'b0);
            chk_cnt("freeze", 1, 2, 3);
        end

        // Release: resumes as if the frozen edges never happened.
        freeze       = 1'b0;
        flush        = 1'b0;
        ex_cond_pass = 1'b1;
        cyc();
        chk_pipe("resume1", 1'b1, 12'hA53, 1'b0, 5'h00, 1'b1, 1'b1);
        chk_cnt("resume1", 1, 2, 3);
        id_ctrl = 12'h013;
        cyc();
        chk_pipe("resume2", 1'b1, 12'h013, 1'b1, 5'h13, 1'b0, 1'b0);
        chk_cnt("resume2", 1, 2, 4);
        id_ctrl = 12'h111;
        cyc();
        chk_pipe("inflight", 1'b1, 12'h111, 1'b1, 5'h13, 1'b1, 1'b1);

        // Mid-stream reset with three instructions in flight.
        reset = 1'b1;
        cyc();
        chk_pipe("mid_reset", 1'b0, 12'h000, 1'b0, 5'h00, 1'b0, 1'b0);
        chk_cnt("mid_reset", 0, 0, 0);

        // First post-reset instruction reaches WB after 3 edges.
        reset   = 1'b0;
        id_ctrl = 12'hA53;
        cyc();
        chk_pipe("post1", 1'b1, 12'hA53, 1'b0, 5'h00, 1'b0, 1'b0);
        cyc();
        chk_pipe("post2", 1'b1, 12'hA53, 1'b1, 5'h13, 1'b0, 1'b0);
        cyc();
        chk_pipe("post3", 1'b1, 12'hA53, 1'b1, 5'h13, 1'b1, 1'b1);
        chk_cnt("post3", 0, 0, 0);

        // 20 retirements into a 4-bit counter saturate at 15.
        for (int i = 0; i < 14; i++) cyc();
        chk_cnt("retire14", 0, 0, 14);
        for (int i = 0; i < 6; i++) cyc();
        chk_cnt("retire_sat", 0, 0, 15);
        chk_pipe("stream_end", 1'b1, 12'hA53, 1'b1, 5'h13, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ctrl_pipe_regs
